cmp_minmax_tracker: RTL and testbench

//  Parametrised, registered magnitude comparator with selectable signed/unsigned mode.

---
 rtl/cmp_minmax_tracker.sv | 103 ++++++++++
 tb/tb_cmp_minmax_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_minmax_tracker.sv
// Registered signed/unsigned magnitude comparator with a running max/min tracker
// on operand a and a saturating count of consecutive equal samples.
module cmp_minmax_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             out_valid,
  output logic             agb,
  output logic             aeb,
  output logic             alb,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic             stats_valid,
  output logic [CNT_W-1:0] eq_run,
  output logic             tracker_state
);

  // Handshake: a sample is taken on every rising edge where in_valid=1; results
  // appear one cycle later qualified by out_valid. There is no back-pressure.

  typedef enum logic {
    EMPTY    = 1'b0,
    TRACKING = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] max_next, min_next;
  logic [CNT_W-1:0] run_next;
  logic             a_eq_b, a_gt_b, a_lt_b;

  function automatic logic greater(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic             sm);
    if (sm) return $signed(x) > $signed(y);
    else    return x > y;
  endfunction

  always_comb begin
    state_next = state;
    max_next   = max_val;
    min_next   = min_val;
    run_next   = eq_run;
    a_eq_b     = (a == b);
    a_gt_b     = greater(a, b, signed_mode);
    a_lt_b     = !a_eq_b && !a_gt_b;

    if (in_valid) begin
      // clr with a sample restarts the tracker from that sample
      if (clr || state == EMPTY) begin
        state_next = TRACKING;
        max_next   = a;
        min_next   = a;
      end else begin
        if (greater(a, max_val, signed_mode)) max_next = a;
        if (greater(min_val, a, signed_mode)) min_next = a;
      end

      if (!a_eq_b)                run_next = '0;
      else if (clr)               run_next = CNT_W'(1);
      else if (eq_run != '1)      run_next = eq_run + CNT_W'(1);
    end else if (clr) begin
      state_next = EMPTY;
      max_next   = '0;
      min_next   = '0;
      run_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      agb       <= 1'b0;
      aeb       <= 1'b0;
      alb       <= 1'b0;
      max_val   <= '0;
      min_val   <= '0;
      eq_run    <= '0;
    end else begin
      state     <= state_next;
      out_valid <= in_valid;
      if (in_valid) begin
        agb <= a_gt_b;
        aeb <= a_eq_b;
        alb <= a_lt_b;
      end
      max_val <= max_next;
      min_val <= min_next;
      eq_run  <= run_next;
    end
  end

  assign stats_valid   = (state == TRACKING);
  assign tracker_state = state;

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Directed and randomized bench for cmp_minmax_tracker (WIDTH=8, CNT_W=2)
// against an arithmetic reference model of compare, tracker and equal-run.
module tb_cmp_minmax_tracker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int RUN_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             clr = 1'b0;
  logic             out_valid, agb, aeb, alb, stats_valid, tracker_state;
  logic [WIDTH-1:0] max_val, min_val;
  logic [CNT_W-1:0] eq_run;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m_ov, m_agb, m_aeb, m_alb, m_stats;
  int m_max, m_min, m_run;

  cmp_minmax_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a), .b(b), .clr(clr), .out_valid(out_valid), .agb(agb), .aeb(aeb),
    .alb(alb), .max_val(max_val), .min_val(min_val), .stats_valid(stats_valid),
    .eq_run(eq_run), .tracker_state(tracker_state)
  );

  always #5 clk = ~clk;

  function automatic int val(input int x, input bit s);
    if (s && x >= 128) return x - 256;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit iv, input bit sm, input int av, input int bv,
                              input bit c, input bit r);
    if (r) begin
      m_ov = 0; m_agb = 0; m_aeb = 0; m_alb = 0;
      m_max = 0; m_min = 0; m_stats = 0; m_run = 0;
      return;
    end
    m_ov = iv;
    if (iv) begin
      m_agb = val(av, sm) > val(bv, sm);
      m_aeb = av == bv;
      m_alb = val(av, sm) < val(bv, sm);
      if (c || !m_stats) begin
        m_max = av; m_min = av; m_stats = 1;
      end else begin
        if (val(av, sm) > val(m_max, sm)) m_max = av;
        if (val(av, sm) < val(m_min, sm)) m_min = av;
      end
      if (av != bv) m_run = 0;
      else if (c)   m_run = 1;
      else          m_run = (m_run + 1 > RUN_MAX) ? RUN_MAX : m_run + 1;
    end else if (c) begin
      m_max = 0; m_min = 0; m_stats = 0; m_run = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_out_valid"}, out_valid, m_ov);
    chk({tag, "_agb"}, agb, m_agb);
    chk({tag, "_aeb"}, aeb, m_aeb);
    chk({tag, "_alb"}, alb, m_alb);
    chk({tag, "_max"}, max_val, m_max);
    chk({tag, "_min"}, min_val, m_min);
    chk({tag, "_stats"}, stats_valid, m_stats);
    chk({tag, "_eq_run"}, eq_run, m_run);
  endtask

  // apply one cycle of inputs, advance the model, then check after the edge
  task automatic step(input string tag, input bit iv, input bit sm, input int av,
                      input int bv, input bit c, input bit r);
    @(negedge clk);
    in_valid = iv; signed_mode = sm; a = av[7:0]; b = bv[7:0]; clr = c; rst = r;
    @(posedge clk);
    model_update(iv, sm, av, bv, c, r);
    #1;
    check_model(tag);
  endtask

  initial begin
    int exp_run[5];
    exp_run = '{1, 2, 3, 3, 3};

    // reset
    step("rst0", 0, 0, 0, 0, 0, 1);
    step("rst1", 1, 0, 5, 5, 1, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_max", max_val, 0);
    chk("rst_eq_run", eq_run, 0);

    // 1: mode
    step("t1u", 1, 0, 8'h80, 8'h7F, 0, 0);
    chk("t1_unsigned_agb", agb, 1);
    chk("t1_unsigned_ov", out_valid, 1);
    step("t1s", 1, 1, 8'h80, 8'h7F, 0, 0);
    chk("t1_signed_alb", alb, 1);

    // 2: equal run with saturation
    for (int i = 0; i < 5; i++) begin
      step("t2", 1, 0, 8'h55, 8'h55, 0, 0);
      chk("t2_eq_run", eq_run, exp_run[i]);
      chk("t2_aeb", aeb, 1);
    end
    step("t2ne", 1, 0, 1, 2, 0, 0);
    chk("t2_eq_run_clear", eq_run, 0);
    chk("t2_alb", alb, 1);

    // 3: tracker unsigned, then signed
    step("t3clr", 0, 0, 0, 0, 1, 0);
    step("t3a", 1, 0, 10, 1, 0, 0);
    chk("t3_stats_first", stats_valid, 1);
    step("t3b", 1, 0, 3, 1, 0, 0);
    step("t3c", 1, 0, 200, 1, 0, 0);
    step("t3d", 1, 0, 50, 1, 0, 0);
    chk("t3_max", max_val, 200);
    chk("t3_min", min_val, 3);
    step("t3sclr", 0, 1, 0, 0, 1, 0);
    step("t3sa", 1, 1, 8'hF0, 0, 0, 0);
    step("t3sb", 1, 1, 8'h05, 0, 0, 0);
    chk("t3_signed_max", max_val, 8'h05);
    chk("t3_signed_min", min_val, 8'hF0);

    // 4: clear with and without a sample
    step("t4a", 1, 0, 7, 7, 1, 0);
    chk("t4_max", max_val, 7);
    chk("t4_min", min_val, 7);
    chk("t4_eq_run", eq_run, 1);
    step("t4b", 0, 0, 0, 0, 1, 0);
    chk("t4_clr_stats", stats_valid, 0);
    chk("t4_clr_max", max_val, 0);

    // 5: bubbles
    step("t5a", 1, 0, 9, 4, 0, 0);
    step("t5b", 0, 0, 99, 1, 0, 0);
    chk("t5_idle_ov", out_valid, 0);
    chk("t5_idle_agb", agb, 1);
    step("t5c", 0, 0, 1, 99, 0, 0);
    chk("t5_idle_max", max_val, 9);
    step("t5d", 1, 0, 4, 4, 0, 0);
    chk("t5_ov", out_valid, 1);

    // 6: reset mid-stream
    step("t6a", 1, 0, 8'h40, 8'h30, 0, 0);
    step("t6rst", 1, 0, 8'h33, 8'h44, 0, 1);
    chk("t6_rst_stats", stats_valid, 0);
    chk("t6_rst_agb", agb, 0);
    step("t6b", 1, 0, 8'h21, 8'h10, 0, 0);
    chk("t6_max", max_val, 8'h21);
    chk("t6_min", min_val, 8'h21);

    // randomized
    for (int i = 0; i < 10000; i++) begin
      int av, bv;
      av = $urandom_range(0, 255);
      bv = ($urandom_range(0, 3) == 0) ? av : $urandom_range(0, 255);
      step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1), av, bv,
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
